rf_loader: RTL

RF_LOADER -- requirements
Module: rf_loader

---
 rtl/rf_pkg.sv | 15 +
 rtl/rf_loader_if.sv | 29 ++
 rtl/rf_loader.sv | 74 +++++++
 3 files changed

// File: rtl/rf_pkg.sv
// Shared types and constants for the register-file loader.
package rf_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } rf_state_e;

    localparam int RF_NWR   = 14;
    localparam int RF_PTR_W = 4;
    localparam int RF_DW    = 8;

endpackage

// File: rtl/rf_loader_if.sv
// Control, memory-read and register-file-write signals of the loader.
interface rf_loader_if
    import rf_pkg::*;
#(
    parameter int DW = RF_DW,
    parameter int AW = 8
);
    logic                start;
    logic [AW-1:0]       base_addr;
    logic [RF_PTR_W-1:0] count;
    logic                mem_rd;
    logic [AW-1:0]       mem_addr;
    logic [DW-1:0]       mem_data;
    logic                rf_we;
    logic [RF_PTR_W-1:0] rf_ptr_w;
    logic [DW-1:0]       rf_di;
    logic                busy;
    logic                done;

    modport master (
        input  start, base_addr, count, mem_data,
        output mem_rd, mem_addr, rf_we, rf_ptr_w, rf_di, busy, done
    );

    modport slave (
        output start, base_addr, count, mem_data,
        input  mem_rd, mem_addr, rf_we, rf_ptr_w, rf_di, busy, done
    );
endinterface

// File: rtl/rf_loader.sv
// Copies up to NWR consecutive memory words into registers 0..n-1;
// one read per cycle, each write trailing its read by one cycle.
module rf_loader
    import rf_pkg::*;
#(
    parameter int DW  = RF_DW,
    parameter int AW  = 8,
    parameter int NWR = RF_NWR
) (
    input  logic         clk,
    input  logic         reset,
    rf_loader_if.master  bus
);
    localparam logic [RF_PTR_W-1:0] N_MAX = RF_PTR_W'(NWR);

    rf_state_e           state;
    logic [RF_PTR_W-1:0] ri;
    logic [RF_PTR_W-1:0] n;
    logic [RF_PTR_W-1:0] wr_ptr;
    logic [AW-1:0]       base;
    logic                wr_stage;
    logic [DW-1:0]       wr_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            ri       <= '0;
            n        <= '0;
            base     <= '0;
            wr_stage <= 1'b0;
            wr_ptr   <= '0;
        end else begin
            // Write stage mirrors the previous RUN cycle and its read index.
            wr_stage <= (state == RUN);
            wr_ptr   <= ri;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.count != '0) begin
                            base  <= bus.base_addr;
                            n     <= (bus.count > N_MAX) ? N_MAX : bus.count;
                            ri    <= '0;
                            state <= RUN;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                RUN: begin
                    ri <= ri + 1'b1;
                    if (ri == n - 1'b1)
                        state <= DRAIN;
                end
                DRAIN:   state <= DONE;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        wr_data      = bus.mem_data;
        bus.mem_rd   = (state == RUN);
        bus.mem_addr = '0;
        if (state == RUN)
            bus.mem_addr = base + AW'(ri);
        bus.rf_we    = wr_stage;
        bus.rf_ptr_w = wr_stage ? wr_ptr : '0;
        bus.rf_di    = wr_stage ? wr_data : '0;
        bus.busy     = (state == RUN) || (state == DRAIN);
        bus.done     = (state == DONE);
    end

endmodule
